// File: rtl/hazard_pkg.sv
// Shared hazard-unit types and constants; the forwarding unit imports the FWD_* selects too.
package hazard_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // One-hot operand-source selects for the forwarding muxes.
    localparam logic [2:0] FWD_REG    = 3'b001;
    localparam logic [2:0] FWD_EX_MEM = 3'b010;
    localparam logic [2:0] FWD_MEM_WB = 3'b100;

endpackage

// File: rtl/mem_wait_timer.sv
// Data-memory freeze sequencer: holds the MEM stage for MEM_LAT cycles per access,
// raising freeze for the first MEM_LAT-1 of them.
module mem_wait_timer
    import hazard_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic freeze
);

    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_LAT > 2) ? (MEM_LAT - 2) : 0);
    localparam bit FREEZE_EN = (MEM_LAT > 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // start is ignored in WAIT so the access being held cannot retrigger itself.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        freeze  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (start && FREEZE_EN) begin
                    freeze  = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    freeze = 1'b1;
                    cnt_d  = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-operand stall and memory-freeze sequencer for the 5-stage MIPS pipeline.
// Define HAZARD_STATS_EN to add the Lu_Stall_Cnt / Br_Stall_Cnt / Freeze_Cnt counters.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int REG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs_IF_ID,
    input  logic [REG_W-1:0] Rt_IF_ID,
    input  logic             Uses_Rt_IF_ID,
    input  logic             Branch_ID,
    input  logic             Branch_Taken_ID,
    input  logic [REG_W-1:0] Rd_ID_EX,
    input  logic             Reg_Write_ID_EX,
    input  logic             Mem_Read_ID_EX,
    input  logic [REG_W-1:0] Rd_EX_MEM,
    input  logic             Mem_Read_EX_MEM,
    input  logic             Mem_Access_EX_MEM,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Bubble,
    output logic             Mem_Busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      Lu_Stall_Cnt,
    output logic [31:0]      Br_Stall_Cnt,
    output logic [31:0]      Freeze_Cnt
`endif
);

    // $0 is hardwired, so a producer writing it never creates a dependency.
    function automatic logic reg_match(
        input logic [REG_W-1:0] r,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rt
    );
        return (r != REG_W'(REG_ZERO)) && ((rs == r) || (uses_rt && (rt == r)));
    endfunction

    logic freeze;
    logic match_ex;
    logic match_mem;
    logic lu_hazard;
    logic br_hazard;
    logic stall;

    mem_wait_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_mem_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (Mem_Access_EX_MEM),
        .freeze (freeze)
    );

    always_comb begin
        match_ex  = reg_match(Rd_ID_EX, Rs_IF_ID, Rt_IF_ID, Uses_Rt_IF_ID);
        match_mem = reg_match(Rd_EX_MEM, Rs_IF_ID, Rt_IF_ID, Uses_Rt_IF_ID);
        lu_hazard = Mem_Read_ID_EX && match_ex;
        br_hazard = Branch_ID && ((Reg_Write_ID_EX && match_ex) ||
                                  (Mem_Read_EX_MEM && match_mem));
        stall     = (lu_hazard || br_hazard) && !freeze;
    end

    // A freeze outranks everything: ID/EX holds through EX_MEM_Write, so no bubble is injected.
    always_comb begin
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Bubble  = 1'b0;
        EX_MEM_Write  = 1'b1;
        MEM_WB_Bubble = 1'b0;
        Mem_Busy      = 1'b0;
        if (freeze) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            EX_MEM_Write  = 1'b0;
            MEM_WB_Bubble = 1'b1;
            Mem_Busy      = 1'b1;
        end else if (stall) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else begin
            IF_ID_Flush = Branch_Taken_ID;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] lu_cnt_q, lu_cnt_d;
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] frz_cnt_q, frz_cnt_d;
    logic        lu_active;
    logic        br_active;

    // Only hazards that actually steer the pipeline are counted; masked ones are not.
    always_comb begin
        lu_active = lu_hazard && !freeze;
        br_active = br_hazard && !freeze;
        lu_cnt_d  = lu_cnt_q + {31'd0, lu_active};
        br_cnt_d  = br_cnt_q + {31'd0, br_active};
        frz_cnt_d = frz_cnt_q + {31'd0, freeze};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt_q  <= '0;
            br_cnt_q  <= '0;
            frz_cnt_q <= '0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            br_cnt_q  <= br_cnt_d;
            frz_cnt_q <= frz_cnt_d;
        end
    end

    assign Lu_Stall_Cnt = lu_cnt_q;
    assign Br_Stall_Cnt = br_cnt_q;
    assign Freeze_Cnt   = frz_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: two controllers (MEM_LAT=3 and MEM_LAT=4) share directed stimulus;
// each cycle's hand-computed outputs are queued and compared by an independent monitor.
`timescale 1ns/1ps
module tb_hazard_stall_controller;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       br_taken;
        logic [4:0] rd_ex;
        logic       rw_ex;
        logic       mr_ex;
        logic [4:0] rd_mem;
        logic       mr_mem;
        logic       ma_mem;
    } stim_t;

    typedef struct {
        string      name;
        logic [6:0] e3;
        logic [6:0] e4;
    } exp_t;

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble, Mem_Busy}
    localparam logic [6:0] DEF = 7'b1100100;
    localparam logic [6:0] STL = 7'b0001100;
    localparam logic [6:0] FLS = 7'b1110100;
    localparam logic [6:0] FRZ = 7'b0000011;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs, rt, rd_ex, rd_mem;
    logic       uses_rt, br, br_taken, rw_ex, mr_ex, mr_mem, ma_mem;

    logic pc3, ifw3, ifl3, bub3, exw3, mwb3, busy3;
    logic pc4, ifw4, ifl4, bub4, exw4, mwb4, busy4;
    logic [6:0] obs3, obs4;

    exp_t sb_q[$];
    int   num_checks = 0;
    int   num_fails  = 0;

`ifdef HAZARD_STATS_EN
    logic [31:0] lu_cnt3, br_cnt3, frz_cnt3, lu_cnt4, br_cnt4, frz_cnt4;
`endif

    always #5 clk = ~clk;

    hazard_stall_controller #(.MEM_LAT(3), .REG_W(5)) dut3 (
        .clk(clk), .rst(rst),
        .Rs_IF_ID(rs), .Rt_IF_ID(rt), .Uses_Rt_IF_ID(uses_rt),
        .Branch_ID(br), .Branch_Taken_ID(br_taken),
        .Rd_ID_EX(rd_ex), .Reg_Write_ID_EX(rw_ex), .Mem_Read_ID_EX(mr_ex),
        .Rd_EX_MEM(rd_mem), .Mem_Read_EX_MEM(mr_mem), .Mem_Access_EX_MEM(ma_mem),
        .PC_Write(pc3), .IF_ID_Write(ifw3), .IF_ID_Flush(ifl3), .ID_EX_Bubble(bub3),
        .EX_MEM_Write(exw3), .MEM_WB_Bubble(mwb3), .Mem_Busy(busy3)
`ifdef HAZARD_STATS_EN
        , .Lu_Stall_Cnt(lu_cnt3), .Br_Stall_Cnt(br_cnt3), .Freeze_Cnt(frz_cnt3)
`endif
    );

    hazard_stall_controller #(.MEM_LAT(4), .REG_W(5)) dut4 (
        .clk(clk), .rst(rst),
        .Rs_IF_ID(rs), .Rt_IF_ID(rt), .Uses_Rt_IF_ID(uses_rt),
        .Branch_ID(br), .Branch_Taken_ID(br_taken),
        .Rd_ID_EX(rd_ex), .Reg_Write_ID_EX(rw_ex), .Mem_Read_ID_EX(mr_ex),
        .Rd_EX_MEM(rd_mem), .Mem_Read_EX_MEM(mr_mem), .Mem_Access_EX_MEM(ma_mem),
        .PC_Write(pc4), .IF_ID_Write(ifw4), .IF_ID_Flush(ifl4), .ID_EX_Bubble(bub4),
        .EX_MEM_Write(exw4), .MEM_WB_Bubble(mwb4), .Mem_Busy(busy4)
`ifdef HAZARD_STATS_EN
        , .Lu_Stall_Cnt(lu_cnt4), .Br_Stall_Cnt(br_cnt4), .Freeze_Cnt(frz_cnt4)
`endif
    );

    assign obs3 = {pc3, ifw3, ifl3, bub3, exw3, mwb3, busy3};
    assign obs4 = {pc4, ifw4, ifl4, bub4, exw4, mwb4, busy4};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        num_checks++;
        if (act !== exp_v) begin
            num_fails++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp_v);
        end
    endtask

    // One stimulus vector per clock; its expected outputs go to the scoreboard.
    task automatic applyStimulus(input string name, input stim_t s,
                                 input logic [6:0] e3, input logic [6:0] e4);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = s.rst;
        rs       = s.rs;
        rt       = s.rt;
        uses_rt  = s.uses_rt;
        br       = s.br;
        br_taken = s.br_taken;
        rd_ex    = s.rd_ex;
        rw_ex    = s.rw_ex;
        mr_ex    = s.mr_ex;
        rd_mem   = s.rd_mem;
        mr_mem   = s.mr_mem;
        ma_mem   = s.ma_mem;
        e.name   = name;
        e.e3     = e3;
        e.e4     = e4;
        sb_q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so each cycle presents one response mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput({e.name, "/lat3"}, {25'd0, obs3}, {25'd0, e.e3});
                checkOutput({e.name, "/lat4"}, {25'd0, obs4}, {25'd0, e.e4});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        rst = 1'b1; rs = '0; rt = '0; uses_rt = 1'b0; br = 1'b0; br_taken = 1'b0;
        rd_ex = '0; rw_ex = 1'b0; mr_ex = 1'b0; rd_mem = '0; mr_mem = 1'b0; ma_mem = 1'b0;
        repeat (2) @(posedge clk);

        s = '0;                                                applyStimulus("reset_state", s, DEF, DEF);
        s = '0; s.mr_ex = 1; s.rw_ex = 1; s.rd_ex = 2; s.rs = 2; applyStimulus("load_use", s, STL, STL);
        s = '0;                                                applyStimulus("load_use_after", s, DEF, DEF);
        s = '0; s.mr_ex = 1; s.rw_ex = 1; s.rd_ex = 0; s.rs = 0; applyStimulus("zero_guard", s, DEF, DEF);
        s = '0; s.mr_ex = 1; s.rd_ex = 5; s.rt = 5;              applyStimulus("rt_unused", s, DEF, DEF);
        s.uses_rt = 1;                                         applyStimulus("rt_used", s, STL, STL);

        s = '0; s.br = 1; s.br_taken = 1; s.rs = 3;
        s.mr_ex = 1; s.rw_ex = 1; s.rd_ex = 3;                 applyStimulus("br_load_c1", s, STL, STL);
        s = '0; s.br = 1; s.br_taken = 1; s.rs = 3;
        s.mr_mem = 1; s.rd_mem = 3;                            applyStimulus("br_load_c2", s, STL, STL);
        s = '0; s.br = 1; s.br_taken = 1; s.rs = 3;            applyStimulus("br_load_c3", s, FLS, FLS);
        s = '0;                                                applyStimulus("br_load_after", s, DEF, DEF);
        s = '0; s.br = 1; s.rt = 7; s.uses_rt = 1;
        s.rw_ex = 1; s.rd_ex = 7;                              applyStimulus("br_alu_c1", s, STL, STL);
        s = '0; s.br = 1; s.rt = 7; s.uses_rt = 1;             applyStimulus("br_alu_c2", s, DEF, DEF);

        s = '0; s.ma_mem = 1;                                  applyStimulus("mem_a1", s, FRZ, FRZ);
        applyStimulus("mem_a2", s, FRZ, FRZ);
        applyStimulus("mem_a3", s, DEF, FRZ);
        applyStimulus("mem_b1", s, FRZ, DEF);
        applyStimulus("mem_b2", s, FRZ, FRZ);
        s = '0;                                                applyStimulus("mem_b3", s, DEF, FRZ);
        applyStimulus("mem_idle1", s, DEF, FRZ);
        applyStimulus("mem_idle2", s, DEF, DEF);

        s = '0; s.ma_mem = 1; s.mr_ex = 1; s.rw_ex = 1; s.rd_ex = 2; s.rs = 2;
        applyStimulus("mask_lu1", s, FRZ, FRZ);
        applyStimulus("mask_lu2", s, FRZ, FRZ);
        applyStimulus("mask_lu3", s, STL, FRZ);
        s.ma_mem = 0;                                          applyStimulus("mask_lu4", s, STL, STL);
        s = '0;                                                applyStimulus("mask_lu_after", s, DEF, DEF);

        s = '0; s.ma_mem = 1;                                  applyStimulus("rst_wait1", s, FRZ, FRZ);
        s.rst = 1;                                             applyStimulus("rst_wait2", s, FRZ, FRZ);
        s = '0;                                                applyStimulus("rst_after", s, DEF, DEF);
`ifdef HAZARD_STATS_EN
        @(negedge clk);
        checkOutput("lu_cnt_rst/lat3", lu_cnt3, 32'd0);
        checkOutput("br_cnt_rst/lat3", br_cnt3, 32'd0);
        checkOutput("frz_cnt_rst/lat3", frz_cnt3, 32'd0);
        checkOutput("frz_cnt_rst/lat4", frz_cnt4, 32'd0);
`endif
        applyStimulus("rst_idle", s, DEF, DEF);

        s = '0; s.ma_mem = 1; s.br = 1; s.br_taken = 1;        applyStimulus("mask_flush1", s, FRZ, FRZ);
        applyStimulus("mask_flush2", s, FRZ, FRZ);
        s.ma_mem = 0;                                          applyStimulus("mask_flush3", s, FLS, FRZ);
        s = '0;                                                applyStimulus("mask_flush_after1", s, DEF, DEF);
        applyStimulus("mask_flush_after2", s, DEF, DEF);
`ifdef HAZARD_STATS_EN
        @(negedge clk);
        checkOutput("lu_cnt_end/lat3", lu_cnt3, 32'd0);
        checkOutput("br_cnt_end/lat4", br_cnt4, 32'd0);
        checkOutput("frz_cnt_end/lat3", frz_cnt3, 32'd2);
        checkOutput("frz_cnt_end/lat4", frz_cnt4, 32'd3);
        checkOutput("lu_cnt_end/lat4", lu_cnt4, 32'd0);
`endif

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            num_checks++;
            num_fails++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
